// File: rtl/instr_loader_if.sv
// Handshake/bus bundle for instr_loader: host-side byte stream and load control in,
// instruction-memory write port and core control out.
interface instr_loader_if #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 64
);
    localparam int LOGSIZE = $clog2(SIZE);

    logic                 load_start;
    logic [LOGSIZE:0]     word_count;
    logic [7:0]           byte_in;
    logic                 byte_valid;
    logic                 byte_ready;
    logic [WIDTH-1:0]     instr_in;
    logic [LOGSIZE+1:0]   instr_wr_addr;
    logic                 instr_wr_en;
    logic                 core_reset;
    logic                 done;
    logic                 err;

    modport master (
        output load_start, word_count, byte_in, byte_valid,
        input  byte_ready, instr_in, instr_wr_addr, instr_wr_en, core_reset, done, err
    );

    modport slave (
        input  load_start, word_count, byte_in, byte_valid,
        output byte_ready, instr_in, instr_wr_addr, instr_wr_en, core_reset, done, err
    );
endinterface

// File: rtl/instr_loader.sv
// Program loader: assembles little-endian bytes into words, writes them to instruction memory,
// then releases the core. Optional trailing checksum byte enabled by INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 64
) (
    input  logic          clk,
    input  logic          reset,
    instr_loader_if.slave bus
);
    localparam int LOGSIZE = $clog2(SIZE);
    localparam logic [LOGSIZE:0] SIZE_W = (LOGSIZE+1)'(SIZE);

`ifdef INSTR_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, RUN, ERROR} state_t;
    localparam state_t FINISH = CHECK;
`else
    typedef enum logic [2:0] {IDLE, RECV, WRITE, RUN} state_t;
    localparam state_t FINISH = RUN;
`endif

    state_t             state_q, state_d;
    logic [LOGSIZE:0]   count_q, count_d;
    logic [LOGSIZE:0]   widx_q, widx_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic [LOGSIZE:0]   clamp;
    logic [LOGSIZE:0]   widx_inc;
    logic               start;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]         sum_q, sum_d;
`endif

    assign clamp    = (bus.word_count > SIZE_W) ? SIZE_W : bus.word_count;
    assign widx_inc = widx_q + (LOGSIZE+1)'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            widx_q  <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            widx_q  <= widx_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d            = state_q;
        count_d            = count_q;
        widx_d             = widx_q;
        bcnt_d             = bcnt_q;
        word_d             = word_q;
        start              = 1'b0;
        bus.byte_ready     = 1'b0;
        bus.instr_in       = '0;
        bus.instr_wr_addr  = '0;
        bus.instr_wr_en    = 1'b0;
        bus.core_reset     = 1'b1;
        bus.done           = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
        sum_d              = sum_q;
        bus.err            = 1'b0;
`endif

        case (state_q)
            IDLE: start = bus.load_start;
            RECV: begin
                bus.byte_ready = 1'b1;
                if (bus.byte_valid) begin
                    word_d[{bcnt_q, 3'b000} +: 8] = bus.byte_in;
                    bcnt_d = bcnt_q + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    sum_d  = sum_q + bus.byte_in;
`endif
                    if (bcnt_q == 2'd3) state_d = WRITE;
                end
            end
            WRITE: begin
                bus.instr_wr_en   = 1'b1;
                bus.instr_in      = word_q;
                bus.instr_wr_addr = {widx_q[LOGSIZE-1:0], 2'b00};
                widx_d            = widx_inc;
                state_d           = (widx_inc == count_q) ? FINISH : RECV;
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            CHECK: begin
                bus.byte_ready = 1'b1;
                if (bus.byte_valid) state_d = (bus.byte_in == sum_q) ? RUN : ERROR;
            end
            ERROR: begin
                bus.err = 1'b1;
                start   = bus.load_start;
            end
`endif
            RUN: begin
                bus.core_reset = 1'b0;
                bus.done       = 1'b1;
                start          = bus.load_start;
            end
            default: state_d = IDLE;
        endcase

        // A new load restarts every counter; a zero-length program skips straight to completion.
        if (start) begin
            count_d = clamp;
            widx_d  = '0;
            bcnt_d  = '0;
            word_d  = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
            state_d = (clamp == '0) ? FINISH : RECV;
        end
    end

`ifndef INSTR_LOADER_CHECKSUM_EN
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: randomized byte streams compared with a word-assembly model.
module tb_instr_loader;
    localparam int WIDTH = 32;
    localparam int SIZE  = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_loader_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bif ();
    instr_loader #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (.clk(clk), .reset(rst_n), .bus(bif));

    int passed = 0;
    int total  = 0;
    logic [7:0]  payload[$];
    int          obs_addr[$];
    logic [31:0] obs_data[$];
    bit bad_ready = 0, bad_idle_out = 0, bad_core = 0, bad_strobe = 0;
    logic prev_wr = 1'b0;

    // Monitor: record every write strobe and flag protocol violations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bif.instr_wr_en) begin
                obs_addr.push_back(int'(bif.instr_wr_addr));
                obs_data.push_back(bif.instr_in);
                if (bif.byte_ready) bad_ready = 1;
                if (prev_wr) bad_strobe = 1;
            end else if (bif.instr_in != '0 || bif.instr_wr_addr != '0) begin
                bad_idle_out = 1;
            end
            if (bif.core_reset == bif.done) bad_core = 1;
            prev_wr = bif.instr_wr_en;
        end else begin
            prev_wr = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Fill payload with words of random bytes (clamped to SIZE), plus checksum trailer if enabled.
    task automatic make_payload(input int n);
        int eff = (n > SIZE) ? SIZE : n;
        payload.delete();
        for (int i = 0; i < eff * 4; i++) payload.push_back(8'($urandom_range(255)));
`ifdef INSTR_LOADER_CHECKSUM_EN
        begin
            logic [7:0] s = 8'd0;
            foreach (payload[i]) s = s + payload[i];
            payload.push_back(s);
        end
`endif
    endtask

    task automatic start_load(input int n);
        @(negedge clk);
        bif.load_start = 1'b1;
        bif.word_count = 7'(n);
        @(negedge clk);
        bif.load_start = 1'b0;
    endtask

    // Stream the first nsend payload bytes with random gaps; optionally pulse load_start mid-stream.
    task automatic send_bytes(input string tag, input int nsend, input int gap, input int inject_at);
        int i = 0;
        int budget = 0;
        bit injected = 0;
        bit v;
        while (i < nsend && budget < 5000) begin
            @(negedge clk);
            v = ($urandom_range(99) >= gap);
            bif.byte_valid = v;
            bif.byte_in    = v ? payload[i] : 8'($urandom_range(255));
            bif.load_start = (i == inject_at && !injected);
            if (bif.load_start) begin
                injected = 1;
                bif.word_count = 7'd1;
            end
            if (v && bif.byte_ready) i++;
            budget++;
        end
        @(negedge clk);
        bif.byte_valid = 1'b0;
        bif.load_start = 1'b0;
        check({tag, "_sent"}, 32'(i), 32'(nsend));
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!bif.done && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, 32'(bif.done), 32'd1);
        check({tag, "_core_rst"}, 32'(bif.core_reset), 32'd0);
    endtask

    // Model: word w is payload bytes 4w..4w+3 little-endian, written at byte address 4w.
    task automatic check_writes(input string tag, input int nwords);
        int n;
        logic [31:0] exp_data;
        check({tag, "_nwr"}, 32'(obs_addr.size()), 32'(nwords));
        n = (obs_addr.size() < nwords) ? obs_addr.size() : nwords;
        for (int w = 0; w < n; w++) begin
            exp_data = 32'(payload[4*w]) + (32'(payload[4*w+1]) << 8)
                     + (32'(payload[4*w+2]) << 16) + (32'(payload[4*w+3]) << 24);
            check({tag, "_addr"}, 32'(obs_addr[w]), 32'(4 * w));
            check({tag, "_data"}, obs_data[w], exp_data);
        end
        obs_addr.delete();
        obs_data.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_rst"}, 32'(bif.core_reset), 32'd1);
        check({tag, "_wr_en"}, 32'(bif.instr_wr_en), 32'd0);
        check({tag, "_ready"}, 32'(bif.byte_ready), 32'd0);
        check({tag, "_done"}, 32'(bif.done), 32'd0);
        check({tag, "_err"}, 32'(bif.err), 32'd0);
        check({tag, "_instr"}, bif.instr_in, 32'd0);
        check({tag, "_addr"}, 32'(bif.instr_wr_addr), 32'd0);
    endtask

    initial begin
        bif.load_start = 1'b0;
        bif.word_count = '0;
        bif.byte_in    = '0;
        bif.byte_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Two-word directed program
        payload = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef INSTR_LOADER_CHECKSUM_EN
        payload.push_back(8'hB6);
`endif
        start_load(2);
        send_bytes("t033", payload.size(), 0, -1);
        wait_done("t033");
        check_writes("t033", 2);
        check("t033_w0", 32'(payload[0]), 32'h13);

        // Reload from RUN: core held again next cycle; gappy stream with ignored load_start
        make_payload(3);
        start_load(3);
        check("t038_core_rst", 32'(bif.core_reset), 32'd1);
        check("t038_done", 32'(bif.done), 32'd0);
        send_bytes("t034", payload.size(), 40, 5);
        wait_done("t034");
        check_writes("t034", 3);
        check("t034_ready_in_write", 32'(bad_ready), 32'd0);

        // Oversized count clamps to SIZE
        make_payload(100);
        start_load(100);
        send_bytes("t035", payload.size(), 0, -1);
        wait_done("t035");
        check("t035_last", (obs_addr.size() > 0) ? 32'(obs_addr[obs_addr.size()-1]) : 32'hFFFF_FFFF, 32'd252);
        check_writes("t035", 64);

        // Reset after 6 bytes of a 2-word load
        make_payload(2);
        start_load(2);
        send_bytes("t036", 6, 0, -1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t036_rst");
        check_writes("t036", 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        make_payload(1);
        start_load(1);
        send_bytes("t036_fresh", payload.size(), 20, -1);
        wait_done("t036_fresh");
        check_writes("t036_fresh", 1);

        // Zero-length program
        make_payload(0);
        start_load(0);
        send_bytes("zero", payload.size(), 0, -1);
        wait_done("zero");
        check_writes("zero", 0);

`ifdef INSTR_LOADER_CHECKSUM_EN
        payload = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        start_load(1);
        send_bytes("t037_ok", payload.size(), 0, -1);
        wait_done("t037_ok");
        check_writes("t037_ok", 1);
        payload = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
        start_load(1);
        send_bytes("t037_bad", payload.size(), 0, -1);
        repeat (3) @(negedge clk);
        check("t037_err", 32'(bif.err), 32'd1);
        check("t037_core_rst", 32'(bif.core_reset), 32'd1);
        check("t037_done", 32'(bif.done), 32'd0);
        check_writes("t037_bad", 1);
        start_load(1);
        check("t037_err_clr", 32'(bif.err), 32'd0);
`endif

        check("no_data_outside_write", 32'(bad_idle_out), 32'd0);
        check("core_rst_vs_done", 32'(bad_core), 32'd0);
        check("single_cycle_strobe", 32'(bad_strobe), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
